// File: rtl/s_div.sv
// SPC700 DIV YA,X unit: nine restoring steps, one per clock.
// Bit-exact quotient, remainder and N/V/H/Z/C flags, including out-of-range operands.
package s_cpu_pkg;
  localparam int AC = 0;
  localparam int AZ = 1;
  localparam int AH = 2;
  localparam int AV = 3;
  localparam int AN = 4;
  localparam int PSW_C = 0;
endpackage

module s_div
  import s_cpu_pkg::*;
#(
  parameter int STEPS = 9
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] ya,
  input  logic [7:0]  x,
  input  logic [7:0]  psw,
  output logic        busy,
  output logic        done,
  output logic [7:0]  a_out,
  output logic [7:0]  y_out,
  output logic [4:0]  flgs
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [3:0]  cnt;
  logic [16:0] yva;
  logic [16:0] dvs;
  logic [16:0] rot;
  logic [16:0] tst;
  logic [16:0] stp;
  logic        h_r;
  logic        c_r;
  logic        last;
  logic        go;
  logic        unused_psw;

  assign unused_psw = ^psw[7:1];

  assign go   = (state == IDLE) && start;
  assign last = (cnt == 4'(STEPS));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Rotate keeps the carried-out bit; the compare sets the
  // quotient bit, which then decides whether to subtract.
  always_comb begin
    rot = {yva[15:0], yva[16]};
    tst = rot;
    if (rot >= dvs) begin
      tst = rot ^ 17'd1;
    end
    stp = tst;
    if (tst[0]) begin
      stp = tst - dvs;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          nxt = DONE;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt   <= '0;
      yva   <= '0;
      dvs   <= '0;
      h_r   <= 1'b0;
      c_r   <= 1'b0;
      a_out <= '0;
      y_out <= '0;
      flgs  <= '0;
    end else begin
      if (go) begin
        cnt <= '0;
        yva <= {1'b0, ya};
        dvs <= {x, 9'b0};
        h_r <= (ya[11:8] >= x[3:0]);
        c_r <= psw[PSW_C];
      end
      if (state == RUN) begin
        if (!last) begin
          yva <= stp;
          cnt <= cnt + 4'd1;
        end else begin
          a_out    <= yva[7:0];
          y_out    <= yva[16:9];
          flgs[AV] <= yva[8];
          flgs[AN] <= yva[7];
          flgs[AZ] <= (yva[7:0] == 8'd0);
          flgs[AH] <= h_r;
          flgs[AC] <= c_r;
        end
      end
    end
  end

endmodule
